// File: rtl/coef_ram_pingpong_if.sv
// Host read/write bus of the ping-pong coefficient memory.
// The master issues requests; the slave (the memory) answers with ready and read data.
interface coef_ram_pingpong_if #(
  parameter int NCH = 2,
  parameter int NB  = 8,
  parameter int W   = 36,
  parameter int AW  = 11
);
  localparam int BW = $clog2(NB);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic              rw_valid;
  logic              rw_ready;
  logic              rw_we;
  logic [CW-1:0]     rw_ch;
  logic [AW+BW-1:0]  rw_addr;
  logic [W-1:0]      rw_wdata;
  logic [W-1:0]      rw_rdata;
  logic              rw_rvalid;

  modport master (
    output rw_valid, rw_we, rw_ch, rw_addr, rw_wdata,
    input  rw_ready, rw_rdata, rw_rvalid
  );

  modport slave (
    input  rw_valid, rw_we, rw_ch, rw_addr, rw_wdata,
    output rw_ready, rw_rdata, rw_rvalid
  );
endinterface

// File: rtl/coef_ram_pingpong.sv
// Multi-channel double-buffered coefficient RAM: filter reads the active page,
// host accesses the shadow page, a per-channel FSM swaps pages on frame_sync.
module coef_ram_pingpong #(
  parameter int NCH          = 2,
  parameter int NB           = 8,
  parameter int W            = 36,
  parameter int AW           = 11,
  parameter int COPY_ON_SWAP = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  coef_ram_pingpong_if.slave    rw,
  input  logic [NCH-1:0]        swap_req,
  input  logic                  frame_sync,
  output logic [NCH-1:0]        swap_pending,
  output logic [NCH-1:0]        active_page,
  input  logic [NCH*AW-1:0]     rd_addr,
  output logic [NCH*NB*W-1:0]   coef
);
  localparam int BW    = $clog2(NB);
  localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {IDLE, PENDING, COPY} swapState_t;

  logic [BW-1:0]          hostBank;
  logic [AW-1:0]          hostRow;
  logic                   chValid;
  logic                   hostWrite;
  logic                   hostRead;
  logic [NCH-1:0]         chIdle;
  logic [W-1:0]           hostRdWord [NCH][NB];
  logic [NB-1:0][W-1:0]   hostRowSel;
  logic [NB-1:0][W-1:0]   hostRowQ;
  logic [BW-1:0]          hostBankQ;
  logic                   hostRvalidQ;

  assign hostBank  = rw.rw_addr[BW-1:0];
  assign hostRow   = rw.rw_addr[AW+BW-1:BW];
  assign chValid   = (int'(rw.rw_ch) < NCH);
  assign rw.rw_ready = chValid && chIdle[rw.rw_ch];
  assign hostWrite = rw.rw_valid && rw.rw_ready && rw.rw_we;
  assign hostRead  = rw.rw_valid && rw.rw_ready && !rw.rw_we;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    swapState_t    state, stateNext;
    logic          page, pageNext;
    logic          latchQ, latchNext;
    logic [AW-1:0] row, rowNext;
    logic          copyEn;
    logic [AW-1:0] rdRow;

    assign rdRow = rd_addr[c*AW +: AW];

    always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of process ordering.
      if (reset) begin
        state  <= IDLE;
        page   <= 1'b0;
        latchQ <= 1'b0;
        row    <= '0;
      end else begin
        state  <= stateNext;
        page   <= pageNext;
        latchQ <= latchNext;
        row    <= rowNext;
      end
    end

    always_comb begin
      // NOTE: every output gets a default first so no path leaves one unassigned,
      // which would otherwise infer a latch.
      stateNext = state;
      pageNext  = page;
      latchNext = latchQ;
      rowNext   = row;
      copyEn    = 1'b0;
      unique case (state)
        IDLE: begin
          if (swap_req[c]) stateNext = PENDING;
        end
        PENDING: begin
          if (frame_sync) begin
            pageNext  = ~page;
            rowNext   = '0;
            stateNext = (COPY_ON_SWAP != 0) ? COPY : IDLE;
          end
        end
        COPY: begin
          copyEn = 1'b1;
          if (swap_req[c]) latchNext = 1'b1;
          if (row == AW'(DEPTH - 1)) begin
            rowNext   = '0;
            latchNext = 1'b0;
            stateNext = (latchQ || swap_req[c]) ? PENDING : IDLE;
          end else begin
            rowNext = row + AW'(1);
          end
        end
        default: stateNext = IDLE;
      endcase
    end

    assign active_page[c]  = page;
    assign swap_pending[c] = (state == PENDING) || latchQ;
    assign chIdle[c]       = (state == IDLE);

    for (genvar b = 0; b < NB; b++) begin : g_bank
      logic [W-1:0] bankMem [2][DEPTH];
      logic [W-1:0] coefQ;

      // NOTE: the RAM array has no reset; contents persist across reset and
      // only the read registers around it are cleared.
      always_ff @(posedge clock) begin
        if (!reset) begin
          if (copyEn)
            bankMem[~page][row] <= bankMem[page][row];
          else if (hostWrite && rw.rw_ch == CW'(c) && hostBank == BW'(b))
            bankMem[~page][hostRow] <= rw.rw_wdata;
        end
      end

      always_ff @(posedge clock) begin
        if (reset) coefQ <= '0;
        else       coefQ <= bankMem[page][rdRow];
      end

      // Bank 0 lands in the most significant word of the channel slice.
      assign coef[(c*NB + NB - 1 - b)*W +: W] = coefQ;
      assign hostRdWord[c][b] = bankMem[~page][hostRow];
    end
  end

  always_comb begin
    hostRowSel = '0;
    for (int b = 0; b < NB; b++) hostRowSel[b] = hostRdWord[rw.rw_ch][b];
  end

  // The whole shadow row and the bank select are captured together, so the
  // read mux only ever sees registered selects.
  always_ff @(posedge clock) begin
    if (reset) begin
      hostRowQ    <= '0;
      hostBankQ   <= '0;
      hostRvalidQ <= 1'b0;
    end else begin
      hostRvalidQ <= hostRead;
      if (hostRead) begin
        hostRowQ  <= hostRowSel;
        hostBankQ <= hostBank;
      end
    end
  end

  assign rw.rw_rdata  = hostRowQ[hostBankQ];
  assign rw.rw_rvalid = hostRvalidQ;
endmodule

// File: tb/tb_coef_ram_pingpong.sv
// Bench for coef_ram_pingpong: directed scenarios plus random traffic, all
// outputs compared every cycle against a page-level behavioural model.
module tb_coef_ram_pingpong;
  localparam int NCH = 2, NB = 8, W = 36, AW = 4, COPY_ON_SWAP = 1;
  localparam int DEPTH = 1 << AW;
  localparam int WORDS = NB * DEPTH;
  localparam int RDW   = NCH * AW;
  localparam int M_IDLE = 0, M_PENDING = 1, M_COPY = 2;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic [NCH-1:0]       swap_req;
  logic                 frame_sync;
  logic [NCH-1:0]       swap_pending;
  logic [NCH-1:0]       active_page;
  logic [RDW-1:0]       rd_addr;
  logic [NCH*NB*W-1:0]  coef;

  always #5 clock = ~clock;

  coef_ram_pingpong_if #(.NCH(NCH), .NB(NB), .W(W), .AW(AW)) rw ();

  coef_ram_pingpong #(
    .NCH(NCH), .NB(NB), .W(W), .AW(AW), .COPY_ON_SWAP(COPY_ON_SWAP)
  ) dut (
    .clock(clock), .reset(reset), .rw(rw.slave),
    .swap_req(swap_req), .frame_sync(frame_sync),
    .swap_pending(swap_pending), .active_page(active_page),
    .rd_addr(rd_addr), .coef(coef)
  );

  int checks = 0;
  int errors = 0;
  bit checkEn = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] coefWord(input int c, input int b);
    return coef[(c*NB + NB - 1 - b)*W +: W];
  endfunction

  // Page-level model: flat coefficient index per page, whole-page copy at the
  // end of the copy window, known-flags for words never written.
  logic [W-1:0] mMem   [NCH][2][WORDS];
  bit           mKnown [NCH][2][WORDS];
  int           mPage [NCH];
  int           mMode [NCH];
  int           mLeft [NCH];
  bit           mLatch[NCH];
  logic [W-1:0] mCoef [NCH][NB];
  bit           mCoefKnown [NCH][NB];
  logic [W-1:0] mRdata;
  bit           mRdataKnown;
  bit           mRvalid;

  always @(posedge clock) begin : model
    int ch, addr, idx;
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        if (mMode[c] == M_COPY)
          for (int i = 0; i < WORDS; i++) mKnown[c][1 - mPage[c]][i] = 1'b0;
        mPage[c] = 0; mMode[c] = M_IDLE; mLeft[c] = 0; mLatch[c] = 1'b0;
        for (int b = 0; b < NB; b++) begin
          mCoef[c][b] = '0; mCoefKnown[c][b] = 1'b1;
        end
      end
      mRdata = '0; mRdataKnown = 1'b1; mRvalid = 1'b0;
    end else begin
      for (int c = 0; c < NCH; c++)
        for (int b = 0; b < NB; b++) begin
          idx = int'(rd_addr[c*AW +: AW]) * NB + b;
          mCoef[c][b]      = mMem[c][mPage[c]][idx];
          mCoefKnown[c][b] = mKnown[c][mPage[c]][idx];
        end
      mRvalid = 1'b0;
      ch   = int'(rw.rw_ch);
      addr = int'(rw.rw_addr);
      if (rw.rw_valid && mMode[ch] == M_IDLE) begin
        if (rw.rw_we) begin
          mMem[ch][1 - mPage[ch]][addr]   = rw.rw_wdata;
          mKnown[ch][1 - mPage[ch]][addr] = 1'b1;
        end else begin
          mRvalid     = 1'b1;
          mRdata      = mMem[ch][1 - mPage[ch]][addr];
          mRdataKnown = mKnown[ch][1 - mPage[ch]][addr];
        end
      end
      for (int c = 0; c < NCH; c++) begin
        case (mMode[c])
          M_IDLE: if (swap_req[c]) mMode[c] = M_PENDING;
          M_PENDING: if (frame_sync) begin
            mPage[c] = 1 - mPage[c];
            mMode[c] = M_COPY;
            mLeft[c] = DEPTH;
          end
          default: begin
            if (swap_req[c]) mLatch[c] = 1'b1;
            mLeft[c]--;
            if (mLeft[c] == 0) begin
              for (int i = 0; i < WORDS; i++) begin
                mMem[c][1 - mPage[c]][i]   = mMem[c][mPage[c]][i];
                mKnown[c][1 - mPage[c]][i] = mKnown[c][mPage[c]][i];
              end
              mMode[c]  = mLatch[c] ? M_PENDING : M_IDLE;
              mLatch[c] = 1'b0;
            end
          end
        endcase
      end
    end
  end

  always @(negedge clock) begin : compare
    logic [NCH-1:0] ePage, ePend;
    if (checkEn) begin
      for (int c = 0; c < NCH; c++) begin
        ePage[c] = mPage[c][0];
        ePend[c] = (mMode[c] == M_PENDING) || mLatch[c];
      end
      check("active_page", 64'(active_page), 64'(ePage));
      check("swap_pending", 64'(swap_pending), 64'(ePend));
      check("rw_ready", 64'(rw.rw_ready), 64'(mMode[int'(rw.rw_ch)] == M_IDLE));
      check("rw_rvalid", 64'(rw.rw_rvalid), 64'(mRvalid));
      if (mRdataKnown) check("rw_rdata", 64'(rw.rw_rdata), 64'(mRdata));
      for (int c = 0; c < NCH; c++)
        for (int b = 0; b < NB; b++)
          if (mCoefKnown[c][b])
            check($sformatf("coef[%0d][%0d]", c, b), 64'(coefWord(c, b)), 64'(mCoef[c][b]));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [W-1:0] randWord();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[W-1:0];
  endfunction

  task automatic hostOp(input bit we, input int ch, input int addr, input logic [W-1:0] d);
    rw.rw_valid = 1'b1;
    rw.rw_we    = we;
    rw.rw_ch    = 1'(ch);
    rw.rw_addr  = 7'(addr);
    rw.rw_wdata = d;
    tick();
    rw.rw_valid = 1'b0;
  endtask

  task automatic fillShadow(input int ch);
    for (int i = 0; i < WORDS; i++) hostOp(1'b1, ch, i, randWord());
  endtask

  task automatic swapCh(input int ch);
    swap_req = NCH'(1 << ch);
    tick();
    swap_req   = '0;
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
  endtask

  task automatic waitIdle(input int ch);
    int n;
    rw.rw_ch = 1'(ch);
    #1;
    n = 0;
    while (!rw.rw_ready && n < 60) begin
      tick();
      n++;
    end
    check($sformatf("wait_idle_ch%0d", ch), 64'(rw.rw_ready), 64'(1));
  endtask

  initial begin
    int n;
    rw.rw_valid = 1'b0; rw.rw_we = 1'b0; rw.rw_ch = '0;
    rw.rw_addr = '0; rw.rw_wdata = '0;
    swap_req = '0; frame_sync = 1'b0; rd_addr = '0;
    reset = 1'b1;
    tick();
    checkEn = 1'b1;
    tick();
    check("reset_active_page", 64'(active_page), 64'(0));
    check("reset_swap_pending", 64'(swap_pending), 64'(0));
    check("reset_rvalid", 64'(rw.rw_rvalid), 64'(0));
    check("reset_rdata", 64'(rw.rw_rdata), 64'(0));
    check("reset_ready", 64'(rw.rw_ready), 64'(1));
    for (int c = 0; c < NCH; c++)
      for (int b = 0; b < NB; b++) check("reset_coef", 64'(coefWord(c, b)), 64'(0));
    reset = 1'b0;

    // Basic update path on channel 0.
    fillShadow(0);
    hostOp(1'b1, 0, 5, 36'h123456789);
    swap_req = 2'b01;
    tick();
    swap_req = '0;
    tick();
    tick();
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    check("t1_active_page0", 64'(active_page[0]), 64'(1));
    tick();
    check("t1_coef_bank5", 64'(coefWord(0, 5)), 64'h123456789);
    waitIdle(0);

    // Prime channel 1 so both of its pages hold known data.
    fillShadow(1);
    hostOp(1'b1, 1, 13, 36'h111);
    swapCh(1);
    check("prime_active_page1", 64'(active_page[1]), 64'(1));
    waitIdle(1);

    // Host read-back; rdata must hold while rw_addr moves.
    hostOp(1'b1, 1, 13, 36'hABC);
    rw.rw_valid = 1'b1; rw.rw_we = 1'b0; rw.rw_ch = 1'b1; rw.rw_addr = 7'd13;
    tick();
    rw.rw_valid = 1'b0;
    rw.rw_addr  = 7'h2A;
    check("rb_rvalid_pulse", 64'(rw.rw_rvalid), 64'(1));
    check("rb_rdata", 64'(rw.rw_rdata), 64'hABC);
    tick();
    check("rb_rvalid_drop", 64'(rw.rw_rvalid), 64'(0));
    check("rb_rdata_hold", 64'(rw.rw_rdata), 64'hABC);

    // Swap gating on channel 1, then copy-window length.
    rd_addr[AW +: AW] = AW'(1);
    swap_req = 2'b10;
    tick();
    swap_req = '0;
    check("gate_pending1", 64'(swap_pending[1]), 64'(1));
    rw.rw_ch = 1'b1; #1;
    check("gate_ready_ch1", 64'(rw.rw_ready), 64'(0));
    rw.rw_ch = 1'b0; #1;
    check("gate_ready_ch0", 64'(rw.rw_ready), 64'(1));
    tick();
    tick();
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    check("gate_toggle", 64'(active_page[1]), 64'(0));
    check("gate_old_page_coef", 64'(coefWord(1, 5)), 64'h111);
    rw.rw_ch = 1'b1; #1;
    n = 0;
    while (!rw.rw_ready && n < 40) begin
      n++;
      tick();
      if (n == 1) check("gate_new_page_coef", 64'(coefWord(1, 5)), 64'hABC);
    end
    check("copy_len", 64'(n), 64'(DEPTH));

    // Swap request during a copy is latched and taken after it.
    swapCh(1);
    tick(); tick(); tick();
    swap_req = 2'b10;
    tick();
    swap_req = '0;
    check("latch_pending", 64'(swap_pending[1]), 64'(1));
    for (int i = 0; i < 20; i++) tick();
    check("latch_still_pending", 64'(swap_pending[1]), 64'(1));
    check("latch_ready_low", 64'(rw.rw_ready), 64'(0));
    check("latch_page_hold", 64'(active_page[1]), 64'(1));
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    check("latch_toggle", 64'(active_page[1]), 64'(0));
    waitIdle(1);
    for (int i = 0; i < WORDS; i++) begin
      hostOp(1'b0, 1, i, '0);
      if (i == 13) check("copy_readback_13", 64'(rw.rw_rdata), 64'hABC);
    end

    // Simultaneous swap_req and frame_sync in IDLE only arms the swap.
    swap_req = 2'b01; frame_sync = 1'b1;
    tick();
    swap_req = '0; frame_sync = 1'b0;
    check("same_cycle_no_toggle", 64'(active_page[0]), 64'(1));
    check("same_cycle_pending", 64'(swap_pending[0]), 64'(1));
    tick();
    check("same_cycle_still_1", 64'(active_page[0]), 64'(1));
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    check("same_cycle_later_toggle", 64'(active_page[0]), 64'(0));
    waitIdle(0);

    // Reset in the middle of a copy.
    swapCh(1);
    tick(); tick(); tick(); tick();
    reset = 1'b1;
    tick();
    rw.rw_ch = 1'b1; #1;
    check("rst_copy_ready", 64'(rw.rw_ready), 64'(1));
    check("rst_copy_page", 64'(active_page), 64'(0));
    check("rst_copy_pending", 64'(swap_pending), 64'(0));
    check("rst_copy_rvalid", 64'(rw.rw_rvalid), 64'(0));
    for (int b = 0; b < NB; b++) check("rst_copy_coef", 64'(coefWord(1, b)), 64'(0));
    reset = 1'b0;

    // Random traffic checked by the model every cycle.
    for (int k = 0; k < 3000; k++) begin
      rw.rw_valid = 1'($urandom_range(0, 1));
      rw.rw_we    = 1'($urandom_range(0, 1));
      rw.rw_ch    = 1'($urandom_range(0, NCH - 1));
      rw.rw_addr  = 7'($urandom_range(0, WORDS - 1));
      rw.rw_wdata = randWord();
      for (int c = 0; c < NCH; c++) swap_req[c] = ($urandom_range(0, 39) == 0);
      frame_sync = ($urandom_range(0, 24) == 0);
      rd_addr    = RDW'($urandom);
      tick();
    end
    rw.rw_valid = 1'b0; swap_req = '0; frame_sync = 1'b0;
    tick();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
